// File: rtl/adder_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_arb_pkg
// Description : Shared types and constants for the adder arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_arb_pkg;

  localparam int OP_W  = 2;
  localparam int SUM_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/adder_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Round-robin picker; first set request at or above the pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_any
);

  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_idx;

  // Scan offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_sum = '0;
    w_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(N_REQ)) begin
        w_sum = w_sum - (ID_W+1)'(N_REQ);
      end
      w_idx = w_sum[ID_W-1:0];
      if (i_req[w_idx]) begin
        o_any = 1'b1;
        o_idx = w_idx;
      end
    end
    if (o_any) begin
      o_gnt[o_idx] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/modulo.sv
`default_nettype none
// ============================================================================
// Module      : modulo
// Description : 2-bit unsigned adder with a full 3-bit sum.
// Revision    : 1.0 - initial release
// ============================================================================
module modulo
  import adder_arb_pkg::*;
(
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic [SUM_W-1:0] y
);

  assign y = {1'b0, a} + {1'b0, b};

endmodule
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : adder_arbiter
// Description : Round-robin sharing of one 2-bit adder among N_REQ requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [OP_W*N_REQ-1:0] req_a,
  input  logic [OP_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [SUM_W-1:0]      rsp_y,
  input  logic                  rsp_ready,
  output logic                  busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_gnt_id;
  logic [OP_W-1:0]  r_op_a;
  logic [OP_W-1:0]  r_op_b;
  logic [SUM_W-1:0] r_rsp_y;

  logic [N_REQ-1:0] w_gnt;
  logic [ID_W-1:0]  w_pick_idx;
  logic             w_any;
  logic [SUM_W-1:0] w_sum;
  logic [OP_W-1:0]  w_a [N_REQ];
  logic [OP_W-1:0]  w_b [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_a[gi] = req_a[OP_W*gi +: OP_W];
      assign w_b[gi] = req_b[OP_W*gi +: OP_W];
    end
  endgenerate

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_any)
  );

  modulo u_add (
    .a (r_op_a),
    .b (r_op_b),
    .y (w_sum)
  );

  // Grant is masked during reset because the reset state itself is IDLE.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    case (r_state)
      S_IDLE: begin
        if (!rst) begin
          req_ready = w_gnt;
        end
        if (w_any) begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: w_state_nxt = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_gnt_id <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_rsp_y  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_any) begin
        r_gnt_id <= w_pick_idx;
        r_op_a   <= w_a[w_pick_idx];
        r_op_b   <= w_b[w_pick_idx];
      end
      if (r_state == S_CALC) begin
        r_rsp_y <= w_sum;
      end
      if (r_state == S_RESP && rsp_ready) begin
        r_ptr <= (r_gnt_id == ID_W'(N_REQ - 1)) ? '0 : r_gnt_id + ID_W'(1);
      end
    end
  end

  assign rsp_valid = (r_state == S_RESP);
  assign busy      = (r_state != S_IDLE);
  assign rsp_id    = r_gnt_id;
  assign rsp_y     = r_rsp_y;

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_arbiter
// Description : Self-checking bench with a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [2*N-1:0] req_a;
  logic [2*N-1:0] req_b;
  logic [N-1:0] req_ready;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [2:0]   rsp_y;
  logic         rsp_ready;
  logic         busy;

  int checks = 0;
  int errors = 0;

  adder_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Model: phase 0 waiting for a grant, 1 computing, 2 result offered.
  int m_phase = 0;
  int m_ptr   = 0;
  int m_id    = 0;
  int m_y     = 0;
  int m_p;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_id = 0; m_y = 0;
    end else begin
      case (m_phase)
        0: begin
          m_p = pick(req_valid, m_ptr);
          if (m_p >= 0) begin
            m_id    = m_p;
            m_y     = int'(req_a[2*m_p +: 2]) + int'(req_b[2*m_p +: 2]);
            m_phase = 1;
          end
        end
        1: m_phase = 2;
        default: begin
          if (rsp_ready) begin
            m_ptr   = (m_id + 1) % N;
            m_phase = 0;
          end
        end
      endcase
    end
  end

  logic [N-1:0] c_exp_rdy;
  int           c_p;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_rsp_y", int'(rsp_y), 0);
      chk("rst_rsp_id", int'(rsp_id), 0);
    end else begin
      c_exp_rdy = '0;
      if (m_phase == 0) begin
        c_p = pick(req_valid, m_ptr);
        if (c_p >= 0) c_exp_rdy[c_p] = 1'b1;
      end
      chk("req_ready", int'(req_ready), int'(c_exp_rdy));
      chk("rsp_valid", int'(rsp_valid), int'(m_phase == 2));
      chk("busy", int'(busy), int'(m_phase != 0));
      if (m_phase == 2) begin
        chk("rsp_id", int'(rsp_id), m_id);
        chk("rsp_y", int'(rsp_y), m_y);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input int a, input int b);
    req_valid[i]     = v;
    req_a[2*i +: 2]  = 2'(a);
    req_b[2*i +: 2]  = 2'(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout actual no response expected rsp_valid at %0t", $time);
    end
  endtask

  // Waits for a response, pins it to literal values, then passes the handshake edge.
  task automatic expect_rsp(input string nm, input int id, input int y);
    bit ok;
    wait_rsp(ok);
    if (ok) begin
      chk({nm, "_id"}, int'(rsp_id), id);
      chk({nm, "_y"}, int'(rsp_y), y);
    end
    step();
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    #1;
    chk("por_req_ready", int'(req_ready), 0);
    chk("por_busy", int'(busy), 0);
    step();
    rst = 1'b0;
    step();

    // Single request: grant now, result two edges later.
    set_req(0, 1, 3, 2);
    #1;
    chk("single_ready", int'(req_ready), 1);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("single_calc_valid", int'(rsp_valid), 0);
    chk("single_calc_busy", int'(busy), 1);
    @(negedge clk);
    chk("single_valid", int'(rsp_valid), 1);
    chk("single_id", int'(rsp_id), 0);
    chk("single_y", int'(rsp_y), 5);
    step();

    // Contention after reset.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1, i, 3);
    for (int k = 0; k < N; k++) expect_rsp("contend", k, k + 3);
    req_valid = '0;
    step();

    // Wrap: serve 1, then 0 and 3 together -> 3 first, then 0.
    set_req(1, 1, 1, 1);
    expect_rsp("wrap_first", 1, 2);
    req_valid = '0;
    set_req(0, 1, 2, 0);
    set_req(3, 1, 3, 1);
    expect_rsp("wrap_a", 3, 4);
    expect_rsp("wrap_b", 0, 2);
    req_valid = '0;
    step();

    // Back-pressure.
    begin
      bit ok;
      rsp_ready = 1'b0;
      set_req(1, 1, 2, 3);
      wait_rsp(ok);
      repeat (5) begin
        step();
        req_valid = '0;
        @(negedge clk);
        chk("bp_valid", int'(rsp_valid), 1);
        chk("bp_id", int'(rsp_id), 1);
        chk("bp_y", int'(rsp_y), 5);
        chk("bp_busy", int'(busy), 1);
        chk("bp_ready", int'(req_ready), 0);
      end
      step();
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_last_valid", int'(rsp_valid), 1);
      @(negedge clk);
      chk("bp_idle_busy", int'(busy), 0);
      step();
    end

    // Reset during CALC.
    set_req(2, 1, 1, 2);
    step();
    req_valid = '0;
    #2;
    rst = 1'b1;
    #1;
    chk("rstcalc_valid", int'(rsp_valid), 0);
    chk("rstcalc_busy", int'(busy), 0);
    step();
    rst = 1'b0;
    set_req(0, 1, 1, 0);
    set_req(3, 1, 2, 2);
    #1;
    chk("rstcalc_ptr0", int'(req_ready), 1);
    req_valid[3] = 1'b0;
    expect_rsp("rstcalc_next", 0, 1);
    req_valid = '0;

    // Reset during RESP.
    begin
      bit ok;
      set_req(3, 1, 3, 3);
      wait_rsp(ok);
      #1;
      rst = 1'b1;
      req_valid = '0;
      #1;
      chk("rstresp_valid", int'(rsp_valid), 0);
      chk("rstresp_busy", int'(busy), 0);
      step();
      rst = 1'b0;
      set_req(0, 1, 0, 1);
      set_req(3, 1, 1, 1);
      #1;
      chk("rstresp_ptr0", int'(req_ready), 1);
      req_valid[3] = 1'b0;
      expect_rsp("rstresp_next", 0, 1);
      req_valid = '0;
    end

    // Exhaustive datapath through requester 2.
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        set_req(2, 1, a, b);
        expect_rsp("exh", 2, a + b);
        req_valid = '0;
      end
    end

    // Randomised traffic; the per-cycle compare process does the checking.
    for (int n = 0; n < 2000; n++) begin
      step();
      rst       = ($urandom_range(0, 299) == 0);
      req_valid = N'($urandom);
      req_a     = (2*N)'($urandom);
      req_b     = (2*N)'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
    end
    step();
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
